// File: rtl/child_lane_arbiter.sv
// child_lane_arbiter
//   Round-robin arbiter that shares one registered passthrough lane among
//   N_REQ requesters. Each cycle it grants at most one requester. The granted
//   word goes into a one-entry output register, tagged with the source index.
//   A wrap-around running sum of every granted word is also kept.
//
// Ports
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   io_req_valid    : [N_REQ]        requester i offers a word
//   io_req_bits     : [N_REQ*WIDTH]  requester i's word at [i*WIDTH +: WIDTH]
//   io_req_ready    : [N_REQ]        one-hot grant (or zero)
//   io_out_valid    : output register holds a word
//   io_out_ready    : downstream accepts the word
//   io_out_bits     : captured word
//   io_out_id       : index of the source that supplied io_out_bits
//   io_clear        : synchronous clear of the accumulator
//   io_acc_sum      : running sum of granted words, modulo 2^WIDTH

// Per-lane data gate: passes the lane's word only when that lane is the winner,
// so the winning word can be picked by OR-reducing all lanes.
module child_lane_arbiter_lane #(
    parameter int WIDTH = 32
) (
    input  logic             gnt_i,
    input  logic [WIDTH-1:0] word_i,
    output logic [WIDTH-1:0] word_o
);
    assign word_o = gnt_i ? word_i : '0;
endmodule

module child_lane_arbiter #(
    parameter int N_REQ = 3,
    parameter int WIDTH = 32,
    localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       io_req_valid,
    input  logic [N_REQ*WIDTH-1:0] io_req_bits,
    output logic [N_REQ-1:0]       io_req_ready,
    output logic                   io_out_valid,
    input  logic                   io_out_ready,
    output logic [WIDTH-1:0]       io_out_bits,
    output logic [IDW-1:0]         io_out_id,
    input  logic                   io_clear,
    output logic [WIDTH-1:0]       io_acc_sum
);
    logic                         out_valid_q, out_valid_d;
    logic [WIDTH-1:0]             out_bits_q,  out_bits_d;
    logic [IDW-1:0]               out_id_q,    out_id_d;
    logic [IDW-1:0]               ptr_q,       ptr_d;
    logic [WIDTH-1:0]             acc_q,       acc_d;

    logic [N_REQ-1:0][WIDTH-1:0]  req_words;
    logic [N_REQ-1:0][WIDTH-1:0]  lane_word;
    logic [N_REQ-1:0]             gnt;
    logic [WIDTH-1:0]             word_g;
    logic [IDW-1:0]               win;
    logic                         found;
    logic                         cap;
    logic                         xfer;

    assign req_words = io_req_bits;

    // The slot can take a new word if it is empty or being drained this cycle.
    assign cap = !out_valid_q || io_out_ready;

    // Search from ptr upwards, wrapping back to 0; first valid requester wins.
    always_comb begin
        logic [IDW:0]   pos;
        logic [IDW-1:0] cand;
        found = 1'b0;
        win   = '0;
        pos   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, ptr_q} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(N_REQ)) pos = pos - (IDW+1)'(N_REQ);
            cand = pos[IDW-1:0];
            if (!found && io_req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign gnt[gi] = found && (win == IDW'(gi));
            child_lane_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
                .gnt_i  (gnt[gi]),
                .word_i (req_words[gi]),
                .word_o (lane_word[gi])
            );
        end
    endgenerate

    always_comb begin
        word_g = '0;
        for (int i = 0; i < N_REQ; i++) word_g = word_g | lane_word[i];
    end

    assign io_req_ready = cap ? gnt : '0;
    assign xfer         = found && cap;

    always_comb begin
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        acc_d       = acc_q;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_bits_d  = word_g;
            out_id_d    = win;
            ptr_d       = (win == IDW'(N_REQ-1)) ? '0 : win + 1'b1;
        end else if (out_valid_q && io_out_ready) begin
            out_valid_d = 1'b0;
        end

        // A clear coinciding with a transfer restarts the sum at the new word.
        if (io_clear) acc_d = '0;
        if (xfer)     acc_d = (io_clear ? '0 : acc_q) + word_g;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
            acc_q       <= acc_d;
        end
    end

    assign io_out_valid = out_valid_q;
    assign io_out_bits  = out_bits_q;
    assign io_out_id    = out_id_q;
    assign io_acc_sum   = acc_q;
endmodule
